// File: rtl/controle_saida.sv
// controle_saida: round-robin arbiter for cpu/entrada display requests with iterative
// 14-bit double-dabble conversion to four BCD digits; digits change only on completion.
module controle_saida #(
    parameter int MAX_VALOR = 9999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_cpu,
    input  logic [31:0] valor_cpu,
    input  logic        req_entrada,
    input  logic [31:0] valor_entrada,
    output logic        ack_cpu,
    output logic        ack_entrada,
    output logic        ocupado,
    output logic [3:0]  d_display1,
    output logic [3:0]  d_display2,
    output logic [3:0]  d_display3,
    output logic [3:0]  d_display4,
    output logic        valido,
    output logic        origem,
    output logic        saturado
);
    typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} estado_t;
    localparam logic [31:0] LIMITE = 32'(MAX_VALOR);
    estado_t estado, proximo;
    logic [3:0] iter;
    logic [13:0] bin;
    logic [15:0] bcd, ajuste;
    logic [29:0] deslocado;
    logic sat_pend, org_pend, ultimo;
    logic grant_cpu, grant_entrada;
    logic [31:0] valor_sel;
    // ultimo = 1 means entrada was served last, so cpu wins a tie
    assign grant_cpu = estado == OCIOSO && req_cpu && (!req_entrada || ultimo);
    assign grant_entrada = estado == OCIOSO && req_entrada && !grant_cpu;
    assign valor_sel = grant_cpu ? valor_cpu : valor_entrada;
    assign ocupado = estado != OCIOSO;
    always_comb begin
        proximo = estado == OCIOSO ? ((grant_cpu || grant_entrada) ? CONVERTE : OCIOSO) :
                  estado == CONVERTE ? (iter == 4'd13 ? ATUALIZA : CONVERTE) : OCIOSO;
    end
    always_comb begin
        ajuste = bcd;
        for (int i = 0; i < 4; i++)
            ajuste[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        deslocado = {ajuste, bin} << 1;
    end
    always_ff @(posedge clock) begin
        if (reset)
            estado <= OCIOSO;
        else
            estado <= proximo;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_cpu <= 1'b0;
            ack_entrada <= 1'b0;
            valido <= 1'b0;
            origem <= 1'b0;
            saturado <= 1'b0;
            d_display1 <= 4'd0;
            d_display2 <= 4'd0;
            d_display3 <= 4'd0;
            d_display4 <= 4'd0;
            bin <= '0;
            bcd <= '0;
            iter <= '0;
            sat_pend <= 1'b0;
            org_pend <= 1'b0;
            ultimo <= 1'b1;
        end else begin
            ack_cpu <= grant_cpu;
            ack_entrada <= grant_entrada;
            valido <= estado == ATUALIZA;
            if (grant_cpu || grant_entrada) begin
                bin <= valor_sel > LIMITE ? LIMITE[13:0] : valor_sel[13:0];
                sat_pend <= valor_sel > LIMITE;
                org_pend <= grant_entrada;
                ultimo <= grant_entrada;
                bcd <= '0;
                iter <= '0;
            end
            if (estado == CONVERTE) begin
                bcd <= deslocado[29:14];
                bin <= deslocado[13:0];
                iter <= iter + 4'd1;
            end
            if (estado == ATUALIZA) begin
                d_display1 <= bcd[15:12];
                d_display2 <= bcd[11:8];
                d_display3 <= bcd[7:4];
                d_display4 <= bcd[3:0];
                origem <= org_pend;
                saturado <= sat_pend;
            end
        end
    end
endmodule

// File: doc/controle_saida.md
CONTROLE_SAIDA -- requirements
Module: controle_saida

Interface
REQ-001 Parameter MAX_VALOR, default 9999, is the saturation limit for displayed values; the valid range is 0..9999.
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  reset; synchronous and active-high.
REQ-004 req_cpu  in  1  level request from the processor output path; held until ack_cpu.
REQ-005 valor_cpu  in  32  unsigned value to display for req_cpu; sampled on the grant edge only.
REQ-006 req_entrada  in  1  level request from the switch-input echo path; held until ack_entrada.
REQ-007 valor_entrada  in  32  unsigned value to display for req_entrada; sampled on the grant edge only.
REQ-008 ack_cpu, ack_entrada  out  1 each  one-cycle grant pulses.
REQ-009 ocupado  out  1  high while a conversion is in progress.
REQ-010 d_display1..d_display4  out  4 each  BCD digits for thousands, hundreds, tens and units; these feed the existing bcd decoders.
REQ-011 valido  out  1  one-cycle pulse when the digit outputs are updated.
REQ-012 origem  out  1  source of the current digits (0 = cpu, 1 = entrada).
REQ-013 saturado  out  1  high when the current digits come from a clamped value.

Function
REQ-014 The FSM SHALL have three states: OCIOSO, CONVERTE and ATUALIZA; ocupado = (state != OCIOSO).
REQ-015 OCIOSO, no request pending: the state SHALL be held and all outputs SHALL hold.
REQ-016 OCIOSO, exactly one request high at edge k: the block SHALL grant that requester.
- The grant SHALL capture that requester's value.
- The matching ack SHALL be 1 for the cycle after edge k only.
- The next state SHALL be CONVERTE with the iteration counter at 0.
REQ-017 Both requests high in OCIOSO: the requester not served last SHALL win (round-robin); the last-served flag resets to entrada, so cpu wins first.
REQ-018 A request arriving while ocupado = 1 SHALL NOT be acked; it SHALL be granted on the first edge spent in OCIOSO with that request still high.
REQ-019 Capture: a value greater than MAX_VALOR SHALL be replaced by MAX_VALOR, with a pending saturation flag set; otherwise the value is used unchanged and the flag is cleared.
REQ-020 The clamped value SHALL fit in 14 bits, and conversion SHALL be iterative shift-and-add-3 (double dabble) over exactly those 14 bits, MSB first.
REQ-021 Each CONVERTE edge SHALL perform one iteration:
- add 3 to every 4-bit BCD nibble that is >= 5;
- then shift {bcd, bin} left by 1;
- after iteration 14 the next state SHALL be ATUALIZA.
REQ-022 The ATUALIZA edge SHALL update d_display1..4, origem and saturado together, pulse valido for one cycle, and set the next state to OCIOSO.
REQ-023 Latency: with a grant at edge k, the new digits and valido SHALL appear after edge k+15, and ocupado SHALL be high for exactly 15 cycles (k+1..k+15).
REQ-024 The digit outputs SHALL keep their previous values during conversion; no partial result SHALL ever be visible.
REQ-025 Back-to-back requests: a request held through ATUALIZA SHALL be granted at edge k+16; the minimum period is 16 cycles per conversion.
REQ-026 Changes to valor_* after the grant edge SHALL NOT affect the conversion in progress.
REQ-027 Every digit output SHALL always be in the range 0..9.

Reset
REQ-028 While reset = 1 at a rising edge, the block SHALL go to OCIOSO and clear its outputs:
- d_display1..4 = 0, valido = 0;
- ack_cpu = ack_entrada = 0;
- origem = 0, saturado = 0;
- ocupado = 0 on the following cycle, with the iteration counter and internal registers cleared and the last-served flag set to entrada.
REQ-029 Reset during CONVERTE or ATUALIZA SHALL abort the conversion with no valido pulse; a request still held after reset releases SHALL be re-granted from the start.
REQ-030 Reset SHALL take priority over any simultaneous request.

Verification
REQ-031 Reset, then req_cpu = 1 with valor_cpu = 1234:
- ack_cpu pulses after edge k and ocupado stays high for 15 cycles;
- then valido pulses with digits 1,2,3,4, origem = 0, saturado = 0.
REQ-032 valor_entrada = 70000 -> digits 9,9,9,9, saturado = 1, origem = 1; a following valor_cpu = 9999 -> 9,9,9,9 with saturado = 0.
REQ-033 Both requests raised together, valor_cpu = 5 and valor_entrada = 42, both held until acked:
- cpu is served first -> 0,0,0,5;
- entrada is granted at k+16 -> 0,0,4,2 with origem = 1;
- a next simultaneous pair is won by cpu.
REQ-034 req_entrada raised during a cpu conversion:
- no ack_entrada until OCIOSO;
- the digits stay at the old value until ATUALIZA;
- valor_cpu changed mid-conversion does not alter the result.
REQ-035 Reset asserted 7 cycles into a conversion of 4321 -> digits 0,0,0,0, no valido, ocupado = 0; with req_cpu still held, a full re-conversion gives 4,3,2,1.
REQ-036 valor_cpu = 0 -> 0,0,0,0 with valido pulsing; valor_cpu = 10000 -> 9,9,9,9 with saturado = 1.
